event_timestamp_fifo: RTL and testbench

Captures a `{secondsSinceBoot, microsecondsSinceBoot}` timestamp on each rising edge of an asynchronous event input. The event input is typically a trigger, PPS or interlock line. Timestamps are queued in a small FIFO that a register-bank reader drains through a valid/ready handshake. The block sits directly downstream of the system-clock interval counters and shares their clock domain.

---
 rtl/event_timestamp_fifo.sv | 155 +++++++++++++++
 tb/tb_event_timestamp_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timestamp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : event_timestamp_fifo
//  Brief    : Timestamps rising edges of an asynchronous event line with the
//             {seconds, microseconds} since-boot counters and queues the
//             captures in a first-word-fall-through FIFO drained by
//             valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module event_timestamp_fifo #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              microsecondsSinceBoot,
  input  logic [31:0]              secondsSinceBoot,
  input  logic                     eventIn,
  input  logic                     enable,
  output logic                     tsValid,
  input  logic                     tsReady,
  output logic [31:0]              tsSeconds,
  output logic [31:0]              tsMicroseconds,
  output logic [FIFO_ADDR_WIDTH:0] fifoCount,
  output logic [31:0]              eventCount,
  output logic [15:0]              droppedCount,
  output logic                     overflow,
  input  logic                     overflowClear
);

  localparam int c_DEPTH  = 1 << FIFO_ADDR_WIDTH;
  localparam int c_HOLD_W = $clog2(SYNC_STAGES + 2);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(SYNC_STAGES + 1);
  localparam logic [FIFO_ADDR_WIDTH:0] c_PTR_ONE = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_prev;
  logic [c_HOLD_W-1:0]      r_holdoff;
  logic [FIFO_ADDR_WIDTH:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH:0] r_rd_ptr;
  logic [63:0]              r_mem [c_DEPTH];
  logic [63:0]              r_head;
  logic [31:0]              r_event_count;
  logic [15:0]              r_dropped;
  logic                     r_overflow;

  logic                     w_sync_out;
  logic                     w_accept;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_write;
  logic                     w_drop;
  logic [FIFO_ADDR_WIDTH:0] w_wr_ptr_next;
  logic [FIFO_ADDR_WIDTH:0] w_rd_ptr_next;
  logic [63:0]              w_wr_data;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  // The holdoff blanks the first detect opportunity after reset, so a line
  // held high through reset is never mistaken for a fresh edge.
  assign w_accept   = w_sync_out & ~r_prev & enable & (r_holdoff == '0);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_ADDR_WIDTH] != r_rd_ptr[FIFO_ADDR_WIDTH]) &&
                   (r_wr_ptr[FIFO_ADDR_WIDTH-1:0] == r_rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign w_pop   = ~w_empty & tsReady;
  // A pop in the same cycle frees the slot a full FIFO needs for the write.
  assign w_write = w_accept & (~w_full | w_pop);
  assign w_drop  = w_accept & w_full & ~w_pop;

  assign w_wr_ptr_next = w_write ? r_wr_ptr + c_PTR_ONE : r_wr_ptr;
  assign w_rd_ptr_next = w_pop   ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;
  assign w_wr_data     = {secondsSinceBoot, microsecondsSinceBoot};

  // Synchronizer chain, edge-detect delay flop and post-reset holdoff counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_holdoff <= c_HOLD_INIT;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], eventIn};
      r_prev <= w_sync_out;
      if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - 1'b1;
      end
    end
  end

  // Storage array; holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= w_wr_data;
    end
  end

  // Read/write pointers; one extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

  // Registered head entry; bypasses the array when the incoming write becomes
  // the new head, and holds its last value once the FIFO runs empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_wr_ptr_next != w_rd_ptr_next) begin
      if (w_write && (r_wr_ptr[FIFO_ADDR_WIDTH-1:0] == w_rd_ptr_next[FIFO_ADDR_WIDTH-1:0])) begin
        r_head <= w_wr_data;
      end else begin
        r_head <= r_mem[w_rd_ptr_next[FIFO_ADDR_WIDTH-1:0]];
      end
    end
  end

  // Event statistics; a drop coincident with a clear leaves one drop recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_event_count <= '0;
      r_dropped     <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_event_count <= r_event_count + 32'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (overflowClear) begin
          r_dropped <= 16'd1;
        end else if (r_dropped != 16'hFFFF) begin
          r_dropped <= r_dropped + 16'd1;
        end
      end else if (overflowClear) begin
        r_overflow <= 1'b0;
        r_dropped  <= '0;
      end
    end
  end

  assign tsValid        = ~w_empty;
  assign tsSeconds      = r_head[63:32];
  assign tsMicroseconds = r_head[31:0];
  assign fifoCount      = r_wr_ptr - r_rd_ptr;
  assign eventCount     = r_event_count;
  assign droppedCount   = r_dropped;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_event_timestamp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_event_timestamp_fifo
//  Brief    : Directed scoreboard bench for event_timestamp_fifo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_event_timestamp_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] usecs;
  logic [31:0] secs;
  logic        eventIn;
  logic        enable;
  logic        tsValid;
  logic        tsReady;
  logic [31:0] tsSeconds;
  logic [31:0] tsMicroseconds;
  logic [4:0]  fifoCount;
  logic [31:0] eventCount;
  logic [15:0] droppedCount;
  logic        overflow;
  logic        overflowClear;

  int          errors = 0;
  int          checks = 0;
  int          exp_ev = 0;
  logic [63:0] sb [$];

  event_timestamp_fifo #(
    .FIFO_ADDR_WIDTH(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .microsecondsSinceBoot(usecs),
    .secondsSinceBoot     (secs),
    .eventIn              (eventIn),
    .enable               (enable),
    .tsValid              (tsValid),
    .tsReady              (tsReady),
    .tsSeconds            (tsSeconds),
    .tsMicroseconds       (tsMicroseconds),
    .fifoCount            (fifoCount),
    .eventCount           (eventCount),
    .droppedCount         (droppedCount),
    .overflow             (overflow),
    .overflowClear        (overflowClear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake the DUT completes must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && tsValid === 1'b1 && tsReady === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: actual=%0h_%0h required=none", tsSeconds, tsMicroseconds);
      end else begin
        check("pop_data", {tsSeconds, tsMicroseconds}, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_ev = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  // One clean pulse: high across two sampling edges, then low for two.
  task automatic pulse(input logic [31:0] s, input logic [31:0] us, input bit store);
    tick();
    secs    = s;
    usecs   = us;
    eventIn = 1'b1;
    exp_ev++;
    if (store) sb.push_back({s, us});
    tick();
    tick();
    eventIn = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    tsReady = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (sb.size() == 0 && tsValid == 1'b0) break;
    end
    check("drain_done", {sb.size() == 0, tsValid}, {1'b1, 1'b0});
    check("drain_count", fifoCount, 0);
    tsReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; usecs = 0; secs = 0; eventIn = 0; enable = 0;
    tsReady = 0; overflowClear = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", tsValid, 0);
    check("rst_sec", tsSeconds, 0);
    check("rst_usec", tsMicroseconds, 0);
    check("rst_count", fifoCount, 0);
    check("rst_events", eventCount, 0);
    check("rst_dropped", droppedCount, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Single capture with latency and detect-cycle sampling.
    enable = 1'b1;
    tick();
    secs = 5; usecs = 123456; eventIn = 1'b1;
    sb.push_back({32'd5, 32'd123458});
    tick(); usecs = 123457; check("lat_e0", tsValid, 0);
    tick(); usecs = 123458; check("lat_e1", tsValid, 0);
    tick(); usecs = 123459;
    check("lat_e2", tsValid, 1);
    check("single_count", fifoCount, 1);
    check("single_events", eventCount, 1);
    check("single_sec", tsSeconds, 5);
    check("single_usec", tsMicroseconds, 123458);
    tick(); eventIn = 1'b0;
    tick(); tick();
    check("single_hold", fifoCount, 1);
    tsReady = 1'b1;
    tick();
    check("single_popped", {tsValid, fifoCount}, 0);
    tsReady = 1'b0;

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 18; i++) pulse(100 + i, 1000 * i + 7, i < 16);
    repeat (3) tick();
    check("fill_count", fifoCount, 16);
    check("fill_events", eventCount, 18);
    check("fill_dropped", droppedCount, 2);
    check("fill_ovf", overflow, 1);
    drain();

    // Clear, refill, then simultaneous pop and write on a full FIFO.
    tick(); overflowClear = 1'b1;
    tick(); overflowClear = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_dropped", droppedCount, 0);
    for (int i = 0; i < 16; i++) pulse(200 + i, i, 1'b1);
    check("full_count", fifoCount, 16);
    tick();
    secs = 300; usecs = 7; eventIn = 1'b1;
    sb.push_back({32'd300, 32'd7});
    exp_ev++;
    tick();
    tick(); eventIn = 1'b0; tsReady = 1'b1;
    tick(); tsReady = 1'b0;
    check("popwr_count", fifoCount, 16);
    check("popwr_ovf", overflow, 0);
    check("popwr_dropped", droppedCount, 0);
    check("popwr_head", tsSeconds, 201);
    check("popwr_events", eventCount, exp_ev);

    pulse(400, 1, 1'b0);
    pulse(401, 2, 1'b0);
    check("drop2_dropped", droppedCount, 2);
    check("drop2_ovf", overflow, 1);
    tick();
    secs = 500; eventIn = 1'b1;
    exp_ev++;
    tick();
    tick(); eventIn = 1'b0; overflowClear = 1'b1;
    tick(); overflowClear = 1'b0;
    check("clrdrop_ovf", overflow, 1);
    check("clrdrop_dropped", droppedCount, 1);
    check("clrdrop_events", eventCount, exp_ev);
    check("clrdrop_count", fifoCount, 16);
    drain();

    // Enable gating.
    enable = 1'b0;
    do_reset();
    tick(); eventIn = 1'b1;
    repeat (4) tick();
    enable = 1'b1;
    repeat (5) tick();
    check("gate_events", eventCount, 0);
    check("gate_count", fifoCount, 0);
    eventIn = 1'b0;
    tick(); tick();
    pulse(9, 99, 1'b1);
    check("gate_next_events", eventCount, 1);
    check("gate_next_count", fifoCount, 1);
    drain();

    // Event line held high through reset, then asynchronous reset with data.
    eventIn = 1'b1;
    do_reset();
    repeat (8) tick();
    check("holdoff_count", fifoCount, 0);
    check("holdoff_events", eventCount, 0);
    eventIn = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) pulse(600 + i, 50 + i, 1'b1);
    check("pre_rst_count", fifoCount, 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", fifoCount, 0);
    check("arst_valid", tsValid, 0);
    check("arst_events", eventCount, 0);
    check("arst_sec", tsSeconds, 0);
    sb.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
